uart_byte_tx: RTL

//  Single-byte UART transmitter; transmit-side counterpart of the single-byte receiver.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_baud_gen.sv | 18 +
 rtl/uart_byte_tx.sv | 74 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding for the transmitter and receiver
package uart_pkg;
    localparam int UART_DATA_W  = 8;
    localparam int UART_BPS_DIV = 5208;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, counts 0..DIV-1 while enabled and ticks on the wrap clock
module uart_baud_gen #(
    parameter int DIV   = 5208,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);
    logic [CNT_W-1:0] cnt_q;
    assign tick_o = en_i && (cnt_q == CNT_W'(DIV - 1));
    // counter runs only while enabled and parks at zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= en_i ? (tick_o ? '0 : cnt_q + 1'b1) : '0;
    end
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: single-byte UART transmitter, 1 start / 8 data LSB first / 1 stop, idle-high;
// define UART_TX_PARITY_EN to insert an even-parity bit between data and stop
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BPS_DIV = UART_BPS_DIV,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send_en,
    input  logic [UART_DATA_W-1:0] parallel_data_tx,
    output logic                   uart_data_tx,
    output logic                   tx_busy,
    output logic                   tx_down
);
`ifdef UART_TX_PARITY_EN
    localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
    localparam uart_state_e AFTER_DATA = ST_STOP;
`endif
    uart_state_e            state_q, state_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] byte_q, byte_d;
    logic                   line_q, line_d;
    logic                   tick, accept;
    assign tx_busy      = state_q != ST_IDLE;
    assign accept       = send_en && !tx_busy;
    assign uart_data_tx = line_q;
    uart_baud_gen #(.DIV(BPS_DIV), .CNT_W(CNT_W)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .en_i   (tx_busy),
        .tick_o (tick)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end
    // next state: every non-idle state lasts whole bit periods, DATA lasts eight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA:   if (tick && bit_q == 3'd7) state_d = AFTER_DATA;
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end
    // outputs: line level is computed from the next state so the pin is registered with no lag
    always_comb begin
        byte_d  = accept ? parallel_data_tx : byte_q;
        bit_d   = (state_q == ST_DATA && tick) ? bit_q + 3'd1 : bit_q;
        line_d  = state_d == ST_START  ? 1'b0 :
                  state_d == ST_DATA   ? byte_q[bit_d] :
                  state_d == ST_PARITY ? ^byte_q : 1'b1;
        tx_down = state_q == ST_STOP && tick;
    end
    // datapath registers: latched byte, data bit index (wraps to 0 after bit 7), serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q <= '0;
            bit_q  <= '0;
            line_q <= 1'b1;
        end else begin
            byte_q <= byte_d;
            bit_q  <= bit_d;
            line_q <= line_d;
        end
    end
endmodule
